// File: rtl/p2s_frame_feeder_if.sv
// Handshake bundle between the frame feeder (master) and the
// parallel-serial converter (slave): data word, start pulse,
// busy status and finish acknowledgement.
interface p2s_frame_feeder_if #(
    parameter int WORD_BITS = 16
);
    logic [WORD_BITS-1:0] p2s_data;
    logic                 p2s_start;
    logic                 p2s_busy;
    logic                 p2s_finish;

    modport master (
        output p2s_data,
        output p2s_start,
        input  p2s_busy,
        input  p2s_finish
    );

    modport slave (
        input  p2s_data,
        input  p2s_start,
        output p2s_busy,
        output p2s_finish
    );
endinterface

// File: rtl/p2s_frame_feeder.sv
// p2s_frame_feeder
// Upstream sequencer for the parallel-serial converter. Snapshots a
// multi-word frame and issues one converter transfer per word, highest
// word index first, waiting for the converter's finish pulse between
// words. A pass is triggered by a pending request (reset, update or
// refresh while busy), an update pulse, or a frame differing from the
// last one sent.
// Optional feature: define FEEDER_REFRESH_EN to add a free-running
// refresh timer that forces a periodic resend of an unchanged frame.
module p2s_frame_feeder #(
    parameter int P_CLK_FREQ = 50,
    parameter int REFRESH_MS = 10,
    parameter int WORD_BITS  = 16,
    parameter int WORDS      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WORDS*WORD_BITS-1:0] frame,
    input  logic                       update,
    p2s_frame_feeder_if.master         p2s,
    output logic                       frame_busy,
    output logic                       frame_done
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int FRAME_W = WORDS * WORD_BITS;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Pick word idx out of a packed frame vector.
    function automatic logic [WORD_BITS-1:0] word_sel(
        input logic [FRAME_W-1:0] vec,
        input logic [IDX_W-1:0]   idx
    );
        word_sel = vec[int'(idx)*WORD_BITS +: WORD_BITS];
    endfunction

    logic [2:0]           state_r;
    logic [2:0]           state_nx_s;
    logic [IDX_W-1:0]     idx_r;
    logic [IDX_W-1:0]     idx_nx_s;
    logic [FRAME_W-1:0]   snap_r;
    logic [FRAME_W-1:0]   sent_r;
    logic                 pending_r;
    logic                 trigger_s;
    logic                 refresh_tick_s;
    logic [WORD_BITS-1:0] issue_word_s;
    logic [WORD_BITS-1:0] p2s_data_r;
    logic                 p2s_start_r;
    logic                 frame_busy_r;
    logic                 frame_done_r;

    // The converter's busy flag is status only; sequencing relies on finish.
    logic unused_busy_s;
    assign unused_busy_s = &{1'b0, p2s.p2s_busy};

`ifdef FEEDER_REFRESH_EN
    localparam int REFRESH_CYCLES = P_CLK_FREQ * 1000 * REFRESH_MS;
    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [CNT_W-1:0] refresh_cnt_r;

    // Free-running refresh timer; wraps at terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt_r <= {CNT_W{1'b0}};
        end else if (refresh_tick_s) begin
            refresh_cnt_r <= {CNT_W{1'b0}};
        end else begin
            refresh_cnt_r <= refresh_cnt_r + CNT_W'(1);
        end
    end

    assign refresh_tick_s = (refresh_cnt_r == CNT_W'(REFRESH_CYCLES - 1));
`else
    logic unused_cfg_s;
    assign unused_cfg_s   = &{1'b0, P_CLK_FREQ[0], REFRESH_MS[0]};
    assign refresh_tick_s = 1'b0;
`endif

    assign trigger_s = pending_r | update | (frame != sent_r);

    // Next-state and next-index decode for the frame sequencer.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) begin
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_nx_s = ST_ISSUE;
                idx_nx_s   = IDX_W'(WORDS - 1);
            end
            ST_ISSUE: begin
                state_nx_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (p2s.p2s_finish) begin
                    if (idx_r == {IDX_W{1'b0}}) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_ISSUE;
                        idx_nx_s   = idx_r - IDX_W'(1);
                    end
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
                idx_nx_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Word for the upcoming ISSUE; in LOAD the snapshot is not yet written, so take it from frame.
    always_comb begin
        if (state_r == ST_LOAD) begin
            issue_word_s = word_sel(frame, idx_nx_s);
        end else begin
            issue_word_s = word_sel(snap_r, idx_nx_s);
        end
    end

    // Sequencer state, snapshot and last-sent frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= {IDX_W{1'b0}};
            snap_r  <= {FRAME_W{1'b0}};
            sent_r  <= {FRAME_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            if (state_r == ST_LOAD) begin
                snap_r <= frame;
            end
            if (state_r == ST_DONE) begin
                sent_r <= snap_r;
            end
        end
    end

    // Resend request: set at reset, by refresh, or by update while a pass is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= 1'b1;
        end else if ((state_r == ST_IDLE) && trigger_s) begin
            pending_r <= 1'b0;
        end else if (refresh_tick_s || (update && (state_r != ST_IDLE))) begin
            pending_r <= 1'b1;
        end
    end

    // Registered outputs, timed to match the state they accompany.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p2s_data_r   <= {WORD_BITS{1'b0}};
            p2s_start_r  <= 1'b0;
            frame_busy_r <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            if (state_nx_s == ST_ISSUE) begin
                p2s_data_r <= issue_word_s;
            end
            p2s_start_r  <= (state_nx_s == ST_ISSUE);
            frame_busy_r <= (state_nx_s != ST_IDLE);
            frame_done_r <= (state_nx_s == ST_DONE);
        end
    end

    assign p2s.p2s_data  = p2s_data_r;
    assign p2s.p2s_start = p2s_start_r;
    assign frame_busy    = frame_busy_r;
    assign frame_done    = frame_done_r;

endmodule

// File: tb/tb_p2s_frame_feeder.sv
// Testbench for p2s_frame_feeder (WORDS=2, WORD_BITS=16). A converter
// model acknowledges each start 20 cycles later; every start is logged
// and compared with the word list predicted from whole-frame passes.
module tb_p2s_frame_feeder;

    localparam int WB = 16;
    localparam int WN = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [WN*WB-1:0] frame = 32'hA5A5_0001;
    logic            update = 1'b0;
    logic            frame_busy;
    logic            frame_done;

    p2s_frame_feeder_if #(.WORD_BITS(WB)) p2s_if ();

    p2s_frame_feeder #(
        .P_CLK_FREQ (1),
        .REFRESH_MS (1),
        .WORD_BITS  (WB),
        .WORDS      (WN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame      (frame),
        .update     (update),
        .p2s        (p2s_if),
        .frame_busy (frame_busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int exp_passes = 0;
    int fin_at = -1;
    logic [WB-1:0] obs_q[$];
    int            obs_cyc[$];
    logic [WB-1:0] exp_q[$];

    // Cycle counter (posedges since time zero).
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Converter model and start/done monitor, evaluated on the falling edge.
    initial begin
        p2s_if.p2s_finish = 1'b0;
        p2s_if.p2s_busy   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fin_at = -1;
                p2s_if.p2s_finish = 1'b0;
                p2s_if.p2s_busy   = 1'b0;
            end else begin
                p2s_if.p2s_finish = (cyc == fin_at);
                if (cyc == fin_at) begin
                    fin_at = -1;
                    p2s_if.p2s_busy = 1'b0;
                end
                if (p2s_if.p2s_start) begin
                    obs_q.push_back(p2s_if.p2s_data);
                    obs_cyc.push_back(cyc);
                    fin_at = cyc + 20;
                    p2s_if.p2s_busy = 1'b1;
                end
                if (frame_done) done_cnt++;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // A whole pass sends the words of f from the highest index down to 0.
    task automatic expect_pass(input logic [WN*WB-1:0] f);
        for (int i = WN - 1; i >= 0; i--) exp_q.push_back(f[i*WB +: WB]);
        exp_passes++;
    endtask

    task automatic wait_starts(input string tag, input int n, input int budget);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_start_seen"}, 32'(obs_q.size() >= n), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int n, input int budget);
        int k = 0;
        while (done_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_done_seen"}, 32'(done_cnt >= n), 32'd1);
        repeat (40) @(negedge clk);
        check_eq({tag, "_idle_busy"}, 32'(frame_busy), 32'd0);
    endtask

    task automatic compare(input string tag);
        int n;
        check_eq({tag, "_nstarts"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_word%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        check_eq({tag, "_ndone"}, 32'(done_cnt), 32'(exp_passes));
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
        done_cnt   = 0;
        exp_passes = 0;
    endtask

    function automatic logic [31:0] new_frame(input logic [31:0] cur);
        logic [31:0] f;
        f = $urandom();
        if (f == cur) f = f ^ 32'h0000_0001;
        return f;
    endfunction

    initial begin
        logic [31:0] f;
        logic [31:0] f2;
        int t;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_start", 32'(p2s_if.p2s_start), 32'd0);
        check_eq("rst_data", 32'(p2s_if.p2s_data), 32'd0);
        check_eq("rst_busy", 32'(frame_busy), 32'd0);
        check_eq("rst_done", 32'(frame_done), 32'd0);

        // 1: first frame is sent after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        t = cyc;
        expect_pass(frame);
        wait_done("t1", 1, 200);
        if (obs_cyc.size() >= 2) begin
            check_eq("t1_latency", 32'(obs_cyc[0] - t), 32'd2);
            check_eq("t1_gap", 32'(obs_cyc[1] - obs_cyc[0]), 32'd21);
        end
        compare("t1");

        // 2: frame changes while idle, several random frames.
        for (int r = 0; r < 4; r++) begin
            f = (r == 0) ? 32'h1234_5678 : new_frame(frame);
            @(negedge clk);
            frame = f;
            t = cyc;
            expect_pass(f);
            wait_done($sformatf("t2_%0d", r), 1, 200);
            if (obs_cyc.size() >= 2) begin
                check_eq($sformatf("t2_%0d_latency", r), 32'(obs_cyc[0] - t), 32'd2);
                check_eq($sformatf("t2_%0d_gap", r), 32'(obs_cyc[1] - obs_cyc[0]), 32'd21);
            end
            compare($sformatf("t2_%0d", r));
        end

        // Update pulse while idle with an unchanged frame forces one resend.
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        expect_pass(frame);
        wait_done("upd_idle", 1, 200);
        compare("upd_idle");

        // 3: update during WAIT of the first word -> one extra full pass.
        f = new_frame(frame);
        @(negedge clk);
        frame = f;
        wait_starts("t3", 1, 50);
        repeat ($urandom_range(2, 15)) @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        expect_pass(f);
        expect_pass(f);
        wait_done("t3", 2, 400);
        compare("t3");

        // 4: frame changes during WAIT -> snapshot finishes, new frame follows.
        f  = new_frame(frame);
        f2 = new_frame(f);
        @(negedge clk);
        frame = f;
        wait_starts("t4", 1, 50);
        repeat ($urandom_range(2, 15)) @(negedge clk);
        frame = f2;
        expect_pass(f);
        expect_pass(f2);
        wait_done("t4", 2, 400);
        compare("t4");

        // 5: reset during WAIT clears outputs asynchronously, frame is resent.
        f = new_frame(frame);
        @(negedge clk);
        frame = f;
        wait_starts("t5", 1, 50);
        repeat ($urandom_range(2, 15)) @(negedge clk);
        check_eq("t5_busy_before", 32'(frame_busy), 32'd1);
        check_eq("t5_data_before", 32'(p2s_if.p2s_data), 32'(f[31:16]));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_busy_async", 32'(frame_busy), 32'd0);
        check_eq("t5_start_async", 32'(p2s_if.p2s_start), 32'd0);
        check_eq("t5_data_async", 32'(p2s_if.p2s_data), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(f[31:16]);
        expect_pass(f);
        wait_done("t5", 1, 200);
        compare("t5");

        // 6: static frame, periodic refresh only when the timer is built in.
`ifdef FEEDER_REFRESH_EN
        wait_starts("t6", 6, 3500);
        if (obs_cyc.size() >= 6) begin
            check_eq("t6_period_a", 32'(obs_cyc[2] - obs_cyc[0]), 32'd1000);
            check_eq("t6_period_b", 32'(obs_cyc[4] - obs_cyc[2]), 32'd1000);
        end
        repeat (30) @(negedge clk);
        done_cnt = 0;
        for (int i = 0; i < 3; i++) expect_pass(frame);
        exp_passes = 0;
        compare("t6");
`else
        repeat (2500) @(negedge clk);
        check_eq("t6_no_resend", 32'(obs_q.size()), 32'd0);
        check_eq("t6_no_done", 32'(done_cnt), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
